// File: rtl/nco_pkg.sv
// Shared constants for the quarter-wave NCO: default widths, pipeline depth,
// valid-fill count and the optional dither LFSR step.
package nco_pkg;

  localparam int DEF_ACC_WIDTH      = 32;
  localparam int DEF_OUT_WIDTH      = 12;
  localparam int DEF_LUT_ADDR_WIDTH = 10;
  localparam int PIPE_LATENCY       = 3;
  localparam int VALID_FILL         = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/nco_qw_rom.sv
// Quarter-wave sine table with two registered read ports; contents are
// computed at elaboration using half-step sample points.
module nco_qw_rom #(
  parameter int OUT_WIDTH      = 12,
  parameter int LUT_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [LUT_ADDR_WIDTH-1:0] addr_a,
  input  logic [LUT_ADDR_WIDTH-1:0] addr_b,
  output logic [OUT_WIDTH-1:0]      data_a,
  output logic [OUT_WIDTH-1:0]      data_b
);

  localparam int DEPTH = 1 << LUT_ADDR_WIDTH;

  function automatic logic [OUT_WIDTH-1:0] tbl_val(input int k);
    real amp;
    real ang;
    amp = real'((1 << (OUT_WIDTH - 1)) - 1);
    ang = 3.141592653589793 / 2.0 * (real'(k) + 0.5) / real'(DEPTH);
    return OUT_WIDTH'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [OUT_WIDTH-1:0] tbl [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
    assign tbl[k] = tbl_val(k);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_a <= '0;
      data_b <= '0;
    end else if (en) begin
      data_a <= tbl[addr_a];
      data_b <= tbl[addr_b];
    end
  end

endmodule

// File: rtl/nco_qw.sv
// Quarter-wave sine/cosine NCO, 4-stage clken-qualified pipeline.
// Optional phase dither is enabled by defining NCO_QW_DITHER_EN.
module nco_qw
  import nco_pkg::*;
#(
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH      = DEF_OUT_WIDTH,
  parameter int LUT_ADDR_WIDTH = DEF_LUT_ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clken,
  input  logic [ACC_WIDTH-1:0] phi_inc_i,
  input  logic [ACC_WIDTH-1:0] phi_ofs_i,
  input  logic                 cfg_load,
  input  logic                 sync_i,
  output logic [OUT_WIDTH-1:0] fsin_o,
  output logic [OUT_WIDTH-1:0] fcos_o,
  output logic                 out_valid
);

  localparam int LOW = ACC_WIDTH - 2 - LUT_ADDR_WIDTH;
  localparam int VCW = $clog2(VALID_FILL + 1);

  logic [ACC_WIDTH-1:0]      inc_r, ofs_r, acc, phase_r, phase_next;
  logic                      sync_pend;
  logic [VCW-1:0]            vcnt;
  logic [1:0]                quad, quad_c;
  logic [LUT_ADDR_WIDTH-1:0] idx, addr_s, addr_c;
  logic                      neg_s_r, neg_c_r;
  logic [OUT_WIDTH-1:0]      mag_s, mag_c;
  logic                      phase_unused;

`ifdef NCO_QW_DITHER_EN
  logic [15:0]          lfsr;
  logic [ACC_WIDTH-1:0] dither;

  always_ff @(posedge clk) begin
    if (reset)      lfsr <= LFSR_SEED;
    else if (clken) lfsr <= lfsr_next(lfsr);
  end

  assign dither     = ACC_WIDTH'(lfsr) & ({ACC_WIDTH{1'b1}} >> (ACC_WIDTH - LOW));
  assign phase_next = acc + ofs_r + dither;
`else
  assign phase_next = acc + ofs_r;
`endif

  // Fold: odd quadrants read the table mirrored; cosine is sine one quadrant on.
  assign quad         = phase_r[ACC_WIDTH-1 -: 2];
  assign idx          = phase_r[ACC_WIDTH-3 -: LUT_ADDR_WIDTH];
  assign quad_c       = quad + 2'd1;
  assign addr_s       = quad[0]   ? ~idx : idx;
  assign addr_c       = quad_c[0] ? ~idx : idx;
  assign phase_unused = ^phase_r[LOW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      inc_r <= '0;
      ofs_r <= '0;
    end else if (cfg_load) begin
      inc_r <= phi_inc_i;
      ofs_r <= phi_ofs_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      phase_r   <= '0;
      sync_pend <= 1'b0;
      vcnt      <= '0;
      neg_s_r   <= 1'b0;
      neg_c_r   <= 1'b0;
      fsin_o    <= '0;
      fcos_o    <= '0;
      out_valid <= 1'b0;
    end else if (clken) begin
      acc       <= (sync_i || sync_pend) ? '0 : acc + inc_r;
      sync_pend <= 1'b0;
      phase_r   <= phase_next;
      neg_s_r   <= quad[1];
      neg_c_r   <= quad_c[1];
      fsin_o    <= neg_s_r ? -mag_s : mag_s;
      fcos_o    <= neg_c_r ? -mag_c : mag_c;
      if (vcnt != VCW'(VALID_FILL)) vcnt <= vcnt + 1'b1;
      out_valid <= (vcnt >= VCW'(VALID_FILL - 1));
    end else if (sync_i) begin
      sync_pend <= 1'b1;
    end
  end

  nco_qw_rom #(
    .OUT_WIDTH      (OUT_WIDTH),
    .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH)
  ) u_rom (
    .clk    (clk),
    .reset  (reset),
    .en     (clken),
    .addr_a (addr_s),
    .addr_b (addr_c),
    .data_a (mag_s),
    .data_b (mag_c)
  );

endmodule

// File: tb/tb_nco_qw.sv
// Directed bench for nco_qw: reset, quadrant sequence, offset, clken gating,
// pending sync, mid-stream reset and a bit-exact golden sweep.
module tb_nco_qw;

  logic        clk = 1'b0;
  logic        reset;
  logic        clken;
  logic [31:0] phi_inc_i;
  logic [31:0] phi_ofs_i;
  logic        cfg_load;
  logic        sync_i;
  logic [11:0] fsin_o;
  logic [11:0] fcos_o;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  int sin_tab [4] = '{2, 2047, -2, -2047};
  int cos_tab [4] = '{2047, -2, -2047, 2};

  nco_qw dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .phi_inc_i (phi_inc_i),
    .phi_ofs_i (phi_ofs_i),
    .cfg_load  (cfg_load),
    .sync_i    (sync_i),
    .fsin_o    (fsin_o),
    .fcos_o    (fcos_o),
    .out_valid (out_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; clken = 1'b0; cfg_load = 1'b0; sync_i = 1'b0;
    phi_inc_i = '0; phi_ofs_i = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic load_cfg(input logic [31:0] inc, input logic [31:0] ofs);
    phi_inc_i = inc; phi_ofs_i = ofs; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  function automatic logic [11:0] rnd_sym(input real x);
    if (x >= 0.0) return 12'($rtoi(x + 0.5));
    else          return 12'(-$rtoi(-x + 0.5));
  endfunction

  // Independent model: full-circle sine at the centre of the 12-bit phase bin.
  task automatic golden(input logic [31:0] ph, output logic [11:0] es, output logic [11:0] ec);
    real th;
    th = 2.0 * 3.141592653589793 * (real'(ph[31:20]) + 0.5) / 4096.0;
    es = rnd_sym(2047.0 * $sin(th));
    ec = rnd_sym(2047.0 * $cos(th));
  endtask

  // scenarios
  task automatic test_reset();
    logic [24:0] exp_v;
    reset = 1'b1; clken = 1'b1; cfg_load = 1'b1; sync_i = 1'b1;
    phi_inc_i = 32'h4000_0000; phi_ofs_i = 32'h8000_0000;
    step(); step();
    checks++;
    if ({out_valid, fsin_o, fcos_o} !== 25'd0) begin
      failures++;
      $display("FAIL reset_state got v=%0b s=%0d c=%0d want 0 0 0", out_valid, $signed(fsin_o), $signed(fcos_o));
    end
    reset = 1'b0; cfg_load = 1'b0; sync_i = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      exp_v = {(n >= 4), 12'd2, 12'd2047};
      checks++;
      if (n >= 3 ? ({out_valid, fsin_o, fcos_o} !== exp_v) : (out_valid !== 1'b0)) begin
        failures++;
        $display("FAIL reset_release n=%0d got v=%0b s=%0d c=%0d want v=%0b s=2 c=2047", n, out_valid, $signed(fsin_o), $signed(fcos_o), exp_v[24]);
      end
    end
  endtask

  task automatic test_quadrants(input logic [31:0] ofs, input bit negate, input string name);
    logic [24:0] exp_v;
    int          sgn;
    sgn = negate ? -1 : 1;
    reset_dut();
    load_cfg(32'h4000_0000, ofs);
    clken = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      exp_v = {(n >= 4), 12'(sgn * sin_tab[(n + 1) % 4]), 12'(sgn * cos_tab[(n + 1) % 4])};
      checks++;
      if (n >= 3 ? ({out_valid, fsin_o, fcos_o} !== exp_v) : (out_valid !== 1'b0)) begin
        failures++;
        $display("FAIL %s n=%0d got v=%0b s=%0d c=%0d want v=%0b s=%0d c=%0d", name, n, out_valid,
                 $signed(fsin_o), $signed(fcos_o), exp_v[24], $signed(exp_v[23:12]), $signed(exp_v[11:0]));
      end
    end
  endtask

  task automatic test_clken_toggle();
    logic [24:0] exp_v;
    int          n;
    reset_dut();
    load_cfg(32'h4000_0000, 32'h0);
    n = 0;
    for (int i = 0; i < 24; i++) begin
      clken = (i % 2 == 0);
      step();
      if (clken) n++;
      exp_v = {(n >= 4), 12'(sin_tab[(n + 1) % 4]), 12'(cos_tab[(n + 1) % 4])};
      checks++;
      if (n >= 3 ? ({out_valid, fsin_o, fcos_o} !== exp_v) : (out_valid !== 1'b0)) begin
        failures++;
        $display("FAIL clken_toggle i=%0d got v=%0b s=%0d c=%0d want v=%0b s=%0d c=%0d", i, out_valid,
                 $signed(fsin_o), $signed(fcos_o), exp_v[24], $signed(exp_v[23:12]), $signed(exp_v[11:0]));
      end
    end
  endtask

  task automatic test_sync_pending();
    logic [24:0] exp_v;
    reset_dut();
    load_cfg(32'h4000_0000, 32'h0);
    clken = 1'b1;
    for (int n = 1; n <= 10; n++) step();
    clken = 1'b0; sync_i = 1'b1;
    for (int h = 0; h < 2; h++) begin
      step();
      sync_i = 1'b0;
      exp_v = {1'b1, 12'(sin_tab[3]), 12'(cos_tab[3])};
      checks++;
      if ({out_valid, fsin_o, fcos_o} !== exp_v) begin
        failures++;
        $display("FAIL sync_hold h=%0d got v=%0b s=%0d c=%0d want v=1 s=-2047 c=2", h, out_valid, $signed(fsin_o), $signed(fcos_o));
      end
    end
    clken = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k <= 3) exp_v = {1'b1, 12'(sin_tab[(k + 7) % 4]), 12'(cos_tab[(k + 7) % 4])};
      else        exp_v = {1'b1, 12'(sin_tab[(k - 4) % 4]), 12'(cos_tab[(k - 4) % 4])};
      checks++;
      if ({out_valid, fsin_o, fcos_o} !== exp_v) begin
        failures++;
        $display("FAIL sync_resume k=%0d got v=%0b s=%0d c=%0d want v=1 s=%0d c=%0d", k, out_valid,
                 $signed(fsin_o), $signed(fcos_o), $signed(exp_v[23:12]), $signed(exp_v[11:0]));
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [24:0] exp_v;
    reset_dut();
    load_cfg(32'h4000_0000, 32'h0);
    clken = 1'b1;
    for (int n = 1; n <= 8; n++) step();
    reset = 1'b1;
    step();
    checks++;
    if ({out_valid, fsin_o, fcos_o} !== 25'd0) begin
      failures++;
      $display("FAIL midreset_state got v=%0b s=%0d c=%0d want 0 0 0", out_valid, $signed(fsin_o), $signed(fcos_o));
    end
    reset = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      step();
      exp_v = {(n >= 4), 12'd2, 12'd2047};
      checks++;
      if (n >= 3 ? ({out_valid, fsin_o, fcos_o} !== exp_v) : (out_valid !== 1'b0)) begin
        failures++;
        $display("FAIL midreset_release n=%0d got v=%0b s=%0d c=%0d want v=%0b s=2 c=2047", n, out_valid, $signed(fsin_o), $signed(fcos_o), exp_v[24]);
      end
    end
  endtask

  task automatic test_golden(input logic [31:0] inc, input logic [31:0] ofs, input int nsamp);
    logic [31:0] ph;
    logic [11:0] es, ec;
    reset_dut();
    load_cfg(inc, ofs);
    clken = 1'b1;
    for (int n = 1; n <= nsamp + 3; n++) begin
      step();
      if (n >= 4) begin
        ph = 32'(n - 3) * inc + ofs;
        golden(ph, es, ec);
        checks++;
        if ({out_valid, fsin_o, fcos_o} !== {1'b1, es, ec}) begin
          failures++;
          $display("FAIL golden inc=%h n=%0d got v=%0b s=%0d c=%0d want v=1 s=%0d c=%0d", inc, n, out_valid,
                   $signed(fsin_o), $signed(fcos_o), $signed(es), $signed(ec));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; clken = 1'b0; cfg_load = 1'b0; sync_i = 1'b0;
    phi_inc_i = '0; phi_ofs_i = '0;
    test_reset();
    test_quadrants(32'h0000_0000, 1'b0, "quadrants");
    test_quadrants(32'h8000_0000, 1'b1, "offset_half");
    test_clken_toggle();
    test_sync_pending();
    test_reset_midstream();
    test_golden(32'hFFFF_FFFF, 32'h0000_0000, 10000);
    test_golden(32'h0123_4567, 32'h3000_0000, 2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
